// File: rtl/global_reset_sequencer_if.sv
// Request/response bundle of the global reset sequencer: reset requests in,
// master reset, staged enables and status out.
interface global_reset_sequencer_if #(
  parameter int N_STAGES = 3
);
  logic                rst_req_n;
  logic                sw_req;
  logic                glb_rst;
  logic [N_STAGES-1:0] stage_en;
  logic                busy;
  logic                done_pulse;

  modport master (
    output rst_req_n, sw_req,
    input  glb_rst, stage_en, busy, done_pulse
  );

  modport slave (
    input  rst_req_n, sw_req,
    output glb_rst, stage_en, busy, done_pulse
  );
endinterface

// File: rtl/global_reset_sequencer.sv
// Ladder-card master reset generator: holds glb_rst for HOLD_CYCLES after the last
// request, then raises N_STAGES thermometer enables STAGE_GAP cycles apart.
module global_reset_sequencer #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int N_STAGES    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  global_reset_sequencer_if.slave  bus
);

  if (HOLD_CYCLES < 2 || HOLD_CYCLES > 65535) begin : g_bad_hold
    $error("global_reset_sequencer: HOLD_CYCLES=%0d outside 2..65535", HOLD_CYCLES);
  end
  if (STAGE_GAP < 1 || STAGE_GAP > 255) begin : g_bad_gap
    $error("global_reset_sequencer: STAGE_GAP=%0d outside 1..255", STAGE_GAP);
  end
  if (N_STAGES < 1 || N_STAGES > 8) begin : g_bad_stages
    $error("global_reset_sequencer: N_STAGES=%0d outside 1..8", N_STAGES);
  end

  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(STAGE_GAP - 1);
  localparam logic [2:0]  STAGE_LAST = 3'(N_STAGES - 1);

  typedef enum logic [1:0] {HOLD, GAP, RUN} state_t;

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic                glb_rst_q, glb_rst_d;
  logic [N_STAGES-1:0] stage_en_q, stage_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sync_meta, sync_q;
  logic                req;

  // Pin request crosses into clk here; both flops idle at 1 (no request).
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b1;
      sync_q    <= 1'b1;
    end else begin
      sync_meta <= bus.rst_req_n;
      sync_q    <= sync_meta;
    end
  end

  assign req = ~sync_q | bus.sw_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HOLD;
      cnt_q      <= '0;
      idx_q      <= '0;
      glb_rst_q  <= 1'b1;
      stage_en_q <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      glb_rst_q  <= glb_rst_d;
      stage_en_q <= stage_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    glb_rst_d  = glb_rst_q;
    stage_en_d = stage_en_q;
    done_d     = 1'b0;

    if (req) begin
      // A request anywhere restarts the hold; it also beats a same-cycle completion.
      state_d    = HOLD;
      cnt_d      = '0;
      glb_rst_d  = 1'b1;
      stage_en_d = '0;
    end else begin
      unique case (state_q)
        HOLD: begin
          glb_rst_d  = 1'b1;
          stage_en_d = '0;
          if (cnt_q == HOLD_LAST) begin
            cnt_d     = '0;
            idx_d     = '0;
            glb_rst_d = 1'b0;
            state_d   = GAP;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            for (int k = 0; k < N_STAGES; k++) begin
              if (idx_q == 3'(k)) stage_en_d[k] = 1'b1;
            end
            if (idx_q == STAGE_LAST) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        RUN: ;
        default: state_d = HOLD;
      endcase
    end

    busy_d = (state_d != RUN);
  end

  assign bus.glb_rst    = glb_rst_q;
  assign bus.stage_en   = stage_en_q;
  assign bus.busy       = busy_q;
  assign bus.done_pulse = done_q;

endmodule

// File: tb/tb_global_reset_sequencer.sv
// Directed bench: t counts clock edges since the last edge that saw rst or a request,
// and expected outputs are closed-form functions of t for each parameter set.
module tb_global_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst_b;

  global_reset_sequencer_if #(.N_STAGES(3)) bus_a ();
  global_reset_sequencer_if #(.N_STAGES(1)) bus_b ();

  global_reset_sequencer #(
    .HOLD_CYCLES(8), .STAGE_GAP(4), .N_STAGES(3)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  global_reset_sequencer #(
    .HOLD_CYCLES(2), .STAGE_GAP(1), .N_STAGES(1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       rst;
    logic       glb;
    logic [2:0] stage;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t pwr [24];

  task automatic check(input string name, input int t, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d: got %0h, expected %0h", name, t, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Closed-form timeline for hold h, gap g, n stages.
  function automatic logic [7:0] exp_stage(input int t, input int h, input int g,
                                           input int n);
    int k;
    if (t < h + g) return 8'd0;
    k = (t - h) / g;
    if (k > n) k = n;
    return 8'((1 << k) - 1);
  endfunction

  task automatic check_a(input string tag, input int t);
    check({tag, ".glb_rst"},  t, 32'(bus_a.glb_rst),    32'(t < 8));
    check({tag, ".stage_en"}, t, 32'(bus_a.stage_en),   32'(exp_stage(t, 8, 4, 3)));
    check({tag, ".busy"},     t, 32'(bus_a.busy),       32'(t < 20));
    check({tag, ".done"},     t, 32'(bus_a.done_pulse), 32'(t == 20));
  endtask

  task automatic check_b(input string tag, input int t);
    check({tag, ".glb_rst"},  t, 32'(bus_b.glb_rst),    32'(t < 2));
    check({tag, ".stage_en"}, t, 32'(bus_b.stage_en),   32'(exp_stage(t, 2, 1, 1)));
    check({tag, ".busy"},     t, 32'(bus_b.busy),       32'(t < 3));
    check({tag, ".done"},     t, 32'(bus_b.done_pulse), 32'(t == 3));
  endtask

  task automatic run_a(input string tag, input int from, input int to);
    for (int t = from; t <= to; t++) begin
      step();
      check_a(tag, t);
    end
  endtask

  task automatic run_b(input string tag, input int from, input int to);
    for (int t = from; t <= to; t++) begin
      step();
      check_b(tag, t);
    end
  endtask

  task automatic sw_pulse_a();
    bus_a.sw_req = 1'b1;
    step();
    bus_a.sw_req = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    rst_b           = 1'b1;
    bus_a.rst_req_n = 1'b1;
    bus_a.sw_req    = 1'b0;
    bus_b.rst_req_n = 1'b1;
    bus_b.sw_req    = 1'b0;

    // Power-up table: row 0 is the last edge with rst high (cycle 0).
    for (int i = 0; i < 24; i++) begin
      pwr[i].rst   = (i == 0);
      pwr[i].glb   = (i < 8);
      pwr[i].stage = (i >= 20) ? 3'b111 : (i >= 16) ? 3'b011 : (i >= 12) ? 3'b001 : 3'b000;
      pwr[i].busy  = (i < 20);
      pwr[i].done  = (i == 20);
    end

    step();
    check_a("reset", 0);
    step();
    check_a("reset", 0);
    for (int i = 0; i < 24; i++) begin
      rst = pwr[i].rst;
      step();
      check("pwr.glb_rst",  i, 32'(bus_a.glb_rst),    32'(pwr[i].glb));
      check("pwr.stage_en", i, 32'(bus_a.stage_en),   32'(pwr[i].stage));
      check("pwr.busy",     i, 32'(bus_a.busy),       32'(pwr[i].busy));
      check("pwr.done",     i, 32'(bus_a.done_pulse), 32'(pwr[i].done));
    end

    // RUN is stable until cycle 30, then sw_req restarts at cycle 31.
    run_a("run_idle", 24, 30);
    sw_pulse_a();
    check_a("sw_run", 0);
    run_a("sw_run", 1, 22);

    // Pin request mid-GAP after stage 0: sampled low on 5 edges (t=14..18).
    sw_pulse_a();
    check_a("pin", 0);
    run_a("pin", 1, 13);
    bus_a.rst_req_n = 1'b0;
    step(); check_a("pin_sync", 14);
    step(); check_a("pin_sync", 15);
    step(); check_a("pin_hold", 0);
    step(); check_a("pin_hold", 0);
    step(); check_a("pin_hold", 0);
    bus_a.rst_req_n = 1'b1;
    step(); check_a("pin_hold", 0);
    step(); check_a("pin_hold", 0);
    run_a("pin_rel", 1, 22);

    // sw_req lands on the final-stage completion edge.
    sw_pulse_a();
    check_a("sw_done", 0);
    run_a("sw_done", 1, 19);
    sw_pulse_a();
    check_a("sw_done_clash", 0);
    run_a("sw_done_after", 1, 22);

    // rst mid-HOLD, then mid-GAP.
    sw_pulse_a();
    check_a("rst_mid", 0);
    run_a("rst_mid", 1, 4);
    rst = 1'b1; step(); rst = 1'b0;
    check_a("rst_hold", 0);
    run_a("rst_hold", 1, 10);
    rst = 1'b1; step(); rst = 1'b0;
    check_a("rst_gap", 0);
    run_a("rst_gap", 1, 22);

    // Corner parameters: HOLD=2, GAP=1, N=1.
    step();
    check_b("b_reset", 0);
    rst_b = 1'b0;
    run_b("b_pwr", 1, 5);
    for (int i = 0; i < 6; i++) begin
      bus_b.sw_req = 1'b1;
      step();
      bus_b.sw_req = 1'b0;
      check_b("b_sw_rep", 0);
      step();
      check_b("b_sw_rep", 1);
    end
    run_b("b_sw_rel", 2, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
